// File: rtl/status_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : status_flag_unit
// Brief    : {C,N,Z} condition-code register with ALU merge, JZ/JN/JC/JMP
//            resolution and an interrupt flag-save LIFO.
// Revision : 1.0 - initial release
// ============================================================================
module status_flag_unit #(
  parameter int STACK_DEPTH = 4,
  parameter bit BYPASS      = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flags_wr_en,
  input  logic [2:0]                         flags_wr_mask,
  input  logic [2:0]                         flags_in,
  input  logic                               branch_valid,
  input  logic [2:0]                         branch_type,
  input  logic                               int_save,
  input  logic                               rti_restore,
  output logic [2:0]                         flags_out,
  output logic                               branch_taken,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CW-1:0] c_full = CW'(STACK_DEPTH);

  localparam logic [2:0] c_br_jz  = 3'b001;
  localparam logic [2:0] c_br_jn  = 3'b010;
  localparam logic [2:0] c_br_jc  = 3'b011;
  localparam logic [2:0] c_br_jmp = 3'b100;

  logic [2:0]    r_flags;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_udf;
  logic [2:0]    r_stack [STACK_DEPTH];

  logic [2:0]    w_merged;
  logic [2:0]    w_eff;
  logic [2:0]    w_nxt;
  logic          w_cond;
  logic [AW-1:0] w_push_ptr;
  logic [AW-1:0] w_pop_ptr;

  // Flag bit order is {C,N,Z}: bit 2 = C, bit 1 = N, bit 0 = Z.
  always_comb begin
    w_merged = flags_wr_en ? ((r_flags & ~flags_wr_mask) | (flags_in & flags_wr_mask))
                           : r_flags;
    w_eff    = BYPASS ? w_merged : r_flags;
    w_cond   = 1'b0;
    case (branch_type)
      c_br_jz:  w_cond = w_eff[0];
      c_br_jn:  w_cond = w_eff[1];
      c_br_jc:  w_cond = w_eff[2];
      c_br_jmp: w_cond = 1'b1;
      default:  w_cond = 1'b0;
    endcase
    branch_taken = rst_n & branch_valid & w_cond;
  end

  // A taken conditional jump consumes its flag, overriding any same-cycle write.
  always_comb begin
    w_nxt = w_merged;
    if (branch_taken) begin
      case (branch_type)
        c_br_jz: w_nxt[0] = 1'b0;
        c_br_jn: w_nxt[1] = 1'b0;
        c_br_jc: w_nxt[2] = 1'b0;
        default: w_nxt = w_merged;
      endcase
    end
  end

  assign w_push_ptr = AW'(r_count);
  assign w_pop_ptr  = AW'(r_count - CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else if (rti_restore) begin
      // Restore wins the cycle: ALU write, branch clear and int_save are dropped.
      if (r_count != '0) begin
        r_flags <= r_stack[w_pop_ptr];
        r_count <= r_count - CW'(1);
      end else begin
        r_flags <= '0;
        r_udf   <= 1'b1;
      end
    end else begin
      r_flags <= w_nxt;
      if (int_save) begin
        if (r_count < c_full) begin
          r_stack[w_push_ptr] <= w_nxt;
          r_count             <= r_count + CW'(1);
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign flags_out       = r_flags;
  assign stack_count     = r_count;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_status_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_status_flag_unit
// Brief    : Scoreboard bench for status_flag_unit (BYPASS=1 and BYPASS=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_status_flag_unit;

  localparam int SIG_FLAGS = 0, SIG_TAKEN = 1, SIG_COUNT = 2, SIG_OVF = 3,
                 SIG_UDF = 4, SIG_NB_FLAGS = 5, SIG_NB_TAKEN = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flags_wr_en = 1'b0;
  logic [2:0] flags_wr_mask = '0;
  logic [2:0] flags_in = '0;
  logic       branch_valid = 1'b0;
  logic [2:0] branch_type = '0;
  logic       int_save = 1'b0;
  logic       rti_restore = 1'b0;

  logic [2:0] d1_flags, d0_flags;
  logic       d1_taken, d0_taken;
  logic [2:0] d1_count, d0_count;
  logic       d1_ovf, d0_ovf, d1_udf, d0_udf;

  typedef struct {
    int         sig;
    logic [3:0] val;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  status_flag_unit #(.STACK_DEPTH(4), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .flags_wr_en(flags_wr_en), .flags_wr_mask(flags_wr_mask), .flags_in(flags_in),
    .branch_valid(branch_valid), .branch_type(branch_type),
    .int_save(int_save), .rti_restore(rti_restore),
    .flags_out(d1_flags), .branch_taken(d1_taken), .stack_count(d1_count),
    .stack_overflow(d1_ovf), .stack_underflow(d1_udf)
  );

  status_flag_unit #(.STACK_DEPTH(4), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .flags_wr_en(flags_wr_en), .flags_wr_mask(flags_wr_mask), .flags_in(flags_in),
    .branch_valid(branch_valid), .branch_type(branch_type),
    .int_save(int_save), .rti_restore(rti_restore),
    .flags_out(d0_flags), .branch_taken(d0_taken), .stack_count(d0_count),
    .stack_overflow(d0_ovf), .stack_underflow(d0_udf)
  );

  function automatic logic [3:0] actual(input int sig);
    case (sig)
      SIG_FLAGS:    return {1'b0, d1_flags};
      SIG_TAKEN:    return {3'b000, d1_taken};
      SIG_COUNT:    return {1'b0, d1_count};
      SIG_OVF:      return {3'b000, d1_ovf};
      SIG_UDF:      return {3'b000, d1_udf};
      SIG_NB_FLAGS: return {1'b0, d0_flags};
      SIG_NB_TAKEN: return {3'b000, d0_taken};
      default:      return 4'hx;
    endcase
  endfunction

  // Monitor: outputs are stable mid-cycle, so every queued expectation is
  // retired on the falling edge that follows its stimulus.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        logic [3:0] a;
        e = sb.pop_front();
        a = actual(e.sig);
        n_tests++;
        if (a !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h at %0t", e.nm, a, e.val, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic expect_sig(input int sig, input logic [3:0] val, input string nm);
    exp_t e;
    e.sig = sig;
    e.val = val;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic we, input logic [2:0] m, input logic [2:0] fi,
                     input logic bv, input logic [2:0] bt, input logic sv, input logic rt);
    @(posedge clk);
    #1;
    flags_wr_en   = we;
    flags_wr_mask = m;
    flags_in      = fi;
    branch_valid  = bv;
    branch_type   = bt;
    int_save      = sv;
    rti_restore   = rt;
  endtask

  task automatic idle();
    cyc(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    // Power-on reset
    @(posedge clk);
    @(posedge clk);
    #1;
    expect_sig(SIG_FLAGS, 4'h0, "por_flags");
    expect_sig(SIG_COUNT, 4'h0, "por_count");
    rst_n = 1'b1;

    // Merge
    cyc(1, 3'b111, 3'b101, 0, 3'b000, 0, 0);
    cyc(1, 3'b010, 3'b010, 0, 3'b000, 0, 0);
    expect_sig(SIG_FLAGS, 4'h5, "merge_setup_101");
    cyc(1, 3'b000, 3'b111, 0, 3'b000, 0, 0);
    expect_sig(SIG_FLAGS, 4'h7, "merge_mask010");
    idle();
    expect_sig(SIG_FLAGS, 4'h7, "merge_mask000_keep");

    // JZ / JC / JN / JMP / reserved
    cyc(1, 3'b111, 3'b001, 0, 3'b000, 0, 0);
    cyc(0, 3'b000, 3'b000, 1, 3'b001, 0, 0);
    expect_sig(SIG_TAKEN, 4'h1, "jz_taken");
    expect_sig(SIG_FLAGS, 4'h1, "jz_flags_before");
    cyc(0, 3'b000, 3'b000, 1, 3'b001, 0, 0);
    expect_sig(SIG_TAKEN, 4'h0, "jz_repeat_not_taken");
    expect_sig(SIG_FLAGS, 4'h0, "jz_cleared_z");
    cyc(1, 3'b111, 3'b010, 0, 3'b000, 0, 0);
    cyc(0, 3'b000, 3'b000, 1, 3'b011, 0, 0);
    expect_sig(SIG_TAKEN, 4'h0, "jc_c0_not_taken");
    expect_sig(SIG_FLAGS, 4'h2, "jc_setup_010");
    cyc(0, 3'b000, 3'b000, 1, 3'b010, 0, 0);
    expect_sig(SIG_TAKEN, 4'h1, "jn_taken");
    expect_sig(SIG_FLAGS, 4'h2, "jc_flags_unchanged");
    cyc(0, 3'b000, 3'b000, 1, 3'b100, 0, 0);
    expect_sig(SIG_TAKEN, 4'h1, "jmp_taken");
    expect_sig(SIG_FLAGS, 4'h0, "jn_cleared_n");
    cyc(0, 3'b000, 3'b000, 1, 3'b101, 0, 0);
    expect_sig(SIG_TAKEN, 4'h0, "reserved_not_taken");
    expect_sig(SIG_NB_FLAGS, 4'h0, "nb_flags_sync");

    // Bypass: same-cycle Z write seen by JZ only when BYPASS=1
    cyc(1, 3'b001, 3'b001, 1, 3'b001, 0, 0);
    expect_sig(SIG_TAKEN, 4'h1, "bypass1_taken");
    expect_sig(SIG_NB_TAKEN, 4'h0, "bypass0_not_taken");
    idle();
    expect_sig(SIG_FLAGS, 4'h0, "bypass1_clear_beats_write");
    expect_sig(SIG_NB_FLAGS, 4'h1, "bypass0_flags_001");

    // LIFO fill, overflow, drain, underflow
    cyc(1, 3'b111, 3'b001, 0, 3'b000, 1, 0);
    expect_sig(SIG_COUNT, 4'h0, "lifo_count0");
    cyc(1, 3'b111, 3'b010, 0, 3'b000, 1, 0);
    expect_sig(SIG_COUNT, 4'h1, "lifo_count1");
    expect_sig(SIG_FLAGS, 4'h1, "lifo_push_inflight");
    cyc(1, 3'b111, 3'b100, 0, 3'b000, 1, 0);
    expect_sig(SIG_COUNT, 4'h2, "lifo_count2");
    cyc(1, 3'b111, 3'b111, 0, 3'b000, 1, 0);
    expect_sig(SIG_COUNT, 4'h3, "lifo_count3");
    cyc(1, 3'b111, 3'b000, 0, 3'b000, 1, 0);
    expect_sig(SIG_COUNT, 4'h4, "lifo_count4");
    expect_sig(SIG_OVF, 4'h0, "lifo_no_ovf_yet");
    cyc(0, 3'b000, 3'b000, 0, 3'b000, 0, 1);
    expect_sig(SIG_COUNT, 4'h4, "lifo_count_sat");
    expect_sig(SIG_OVF, 4'h1, "lifo_overflow");
    expect_sig(SIG_FLAGS, 4'h0, "lifo_flags_after_5th");
    cyc(1, 3'b111, 3'b011, 1, 3'b100, 1, 1);
    expect_sig(SIG_FLAGS, 4'h7, "pop1_111");
    expect_sig(SIG_COUNT, 4'h3, "pop1_count");
    cyc(0, 3'b000, 3'b000, 0, 3'b000, 0, 1);
    expect_sig(SIG_FLAGS, 4'h4, "pop2_100");
    expect_sig(SIG_COUNT, 4'h2, "pop2_count");
    cyc(0, 3'b000, 3'b000, 0, 3'b000, 0, 1);
    expect_sig(SIG_FLAGS, 4'h2, "pop3_010");
    cyc(0, 3'b000, 3'b000, 0, 3'b000, 0, 1);
    expect_sig(SIG_FLAGS, 4'h1, "pop4_001");
    expect_sig(SIG_COUNT, 4'h0, "pop4_count");
    expect_sig(SIG_UDF, 4'h0, "no_udf_yet");
    idle();
    expect_sig(SIG_FLAGS, 4'h0, "pop5_flags000");
    expect_sig(SIG_UDF, 4'h1, "underflow");
    expect_sig(SIG_COUNT, 4'h0, "underflow_count");
    expect_sig(SIG_OVF, 4'h1, "ovf_sticky");

    // Asynchronous reset with two entries saved
    cyc(1, 3'b111, 3'b101, 0, 3'b000, 1, 0);
    cyc(1, 3'b111, 3'b011, 0, 3'b000, 1, 0);
    idle();
    expect_sig(SIG_COUNT, 4'h2, "prereset_count2");
    expect_sig(SIG_FLAGS, 4'h3, "prereset_flags");
    @(posedge clk);
    #2;
    rst_n        = 1'b0;
    branch_valid = 1'b1;
    branch_type  = 3'b100;
    expect_sig(SIG_FLAGS, 4'h0, "rst_flags");
    expect_sig(SIG_COUNT, 4'h0, "rst_count");
    expect_sig(SIG_OVF, 4'h0, "rst_ovf");
    expect_sig(SIG_UDF, 4'h0, "rst_udf");
    expect_sig(SIG_TAKEN, 4'h0, "rst_taken_low");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();

    // int_save + rti_restore collision
    cyc(1, 3'b111, 3'b110, 0, 3'b000, 1, 0);
    cyc(1, 3'b111, 3'b001, 0, 3'b000, 0, 0);
    expect_sig(SIG_COUNT, 4'h1, "coll_count1");
    expect_sig(SIG_FLAGS, 4'h6, "coll_flags110");
    cyc(0, 3'b000, 3'b000, 0, 3'b000, 1, 1);
    expect_sig(SIG_FLAGS, 4'h1, "coll_flags001");
    idle();
    expect_sig(SIG_FLAGS, 4'h6, "coll_restored");
    expect_sig(SIG_COUNT, 4'h0, "coll_count0");
    expect_sig(SIG_OVF, 4'h0, "coll_no_ovf");
    expect_sig(SIG_UDF, 4'h0, "coll_no_udf");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
